// File: rtl/digdug_cus06xx.sv
// digdug_cus06xx: CPU-to-I/O bridge with an optional periodic NMI timer (DIGDUG_CUS06XX_NMI_EN).
module digdug_cus06xx #(
  parameter int PERIOD_BASE = 2400,
  parameter int NMI_WIDTH = 200
) (
  input  logic       CL,
  input  logic       RESET,
  input  logic       CPU_CS,
  input  logic       CPU_WR,
  input  logic       CPU_RD,
  input  logic       CPU_A,
  input  logic [7:0] CPU_DI,
  output logic [7:0] CPU_DO,
  output logic       NMI,
  output logic       IO_CS,
  output logic       IO_WR,
  output logic [4:0] IO_AD,
  output logic [7:0] IO_DO,
  input  logic [7:0] IO_DI
);
  logic [7:0] ctrl;
  logic [3:0] idx, pa;
  logic cmd, en_wr, en_rd, ctl_wr, dat_wr, dat_rd;
  assign en_wr = ctrl[0] & ~ctrl[4];
  assign en_rd = ctrl[0] & ctrl[4];
  assign ctl_wr = CPU_CS & CPU_WR & CPU_A;
  assign dat_wr = CPU_CS & CPU_WR & ~CPU_A & en_wr;
  assign dat_rd = CPU_CS & CPU_RD & ~CPU_WR & ~CPU_A & en_rd;
  always_ff @(posedge CL or posedge RESET)
    if (RESET) begin
      ctrl <= '0;
      idx <= '0;
      pa <= '0;
      cmd <= 1'b0;
      IO_CS <= 1'b0;
      IO_WR <= 1'b0;
      IO_DO <= '0;
    end else begin
      IO_CS <= ctl_wr | dat_wr;
      IO_WR <= ctl_wr | dat_wr;
      cmd <= ctl_wr;
      pa <= idx;
      if (ctl_wr | dat_wr) IO_DO <= CPU_DI;
      if (ctl_wr) ctrl <= CPU_DI;
      idx <= ctl_wr ? 4'd0 : (dat_wr | dat_rd) ? idx + 4'd1 : idx;
    end
  // the pulse address is captured with the pulse; between pulses the bus shows the live index
  assign IO_AD = IO_WR ? (cmd ? 5'h10 : {1'b0, pa}) : {1'b0, idx};
  assign CPU_DO = CPU_A ? ctrl : en_rd ? IO_DI : 8'hFF;
`ifdef DIGDUG_CUS06XX_NMI_EN
  localparam int CW = $clog2(7 * PERIOD_BASE + 1);
  logic [CW-1:0] cnt, p;
  assign p = CW'(ctrl[7:5] * PERIOD_BASE);
  assign NMI = (p != '0) && (cnt >= p - CW'(NMI_WIDTH));
  always_ff @(posedge CL or posedge RESET)
    if (RESET) cnt <= '0;
    else if (ctl_wr || p == '0) cnt <= '0;
    else cnt <= (cnt == p - 1'b1) ? '0 : cnt + 1'b1;
`else
  assign NMI = 1'b0;
`endif
endmodule
